// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The unit connects through the slave modport; the CPU/memory side uses master.
interface load_store_unit_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_LOAD;
    logic        REQ_STORE;
    logic [2:0]  FUNCT3;
    logic [31:0] BASE;
    logic [31:0] OFFSET;
    logic [31:0] STORE_DATA;
    logic        RESP_VALID;
    logic        RESP_READY;
    logic [31:0] RESP_DATA;
    logic [1:0]  RESP_FAULT;
    logic [3:0]  MEM_RW_EN;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic [31:0] LOAD_CNT;
    logic [31:0] STORE_CNT;

    modport slave (
        input  REQ_VALID, REQ_LOAD, REQ_STORE, FUNCT3, BASE, OFFSET, STORE_DATA,
        input  RESP_READY, MEM_READDATA,
        output REQ_READY, RESP_VALID, RESP_DATA, RESP_FAULT,
        output MEM_RW_EN, MEM_ADDRESS, MEM_WRITEDATA, LOAD_CNT, STORE_CNT
    );

    modport master (
        output REQ_VALID, REQ_LOAD, REQ_STORE, FUNCT3, BASE, OFFSET, STORE_DATA,
        output RESP_READY, MEM_READDATA,
        input  REQ_READY, RESP_VALID, RESP_DATA, RESP_FAULT,
        input  MEM_RW_EN, MEM_ADDRESS, MEM_WRITEDATA, LOAD_CNT, STORE_CNT
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: checks a request, issues one memory
// command, and returns load data or store completion with fault status.
module load_store_unit #(
    parameter int unsigned MEM_BYTES   = 524288,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input logic              CLK,
    input logic              RESET_N,
    load_store_unit_if.slave lsu
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [32:0] LAST_BYTE_C = 33'(MEM_BYTES) - 33'd1;

    state_t      state_r;
    state_t      state_next_s;
    logic        ready_r;
    logic        resp_valid_r;
    logic        is_load_r;
    logic [31:0] resp_data_r;
    logic [1:0]  resp_fault_r;
    logic [3:0]  mem_rw_en_r;
    logic [31:0] mem_address_r;
    logic [31:0] mem_writedata_r;
    logic [31:0] load_cnt_r;
    logic [31:0] store_cnt_r;

    logic [31:0] ea_s;
    logic [32:0] size_s;
    logic [32:0] last_s;
    logic [3:0]  cmd_s;
    logic        illegal_s;
    logic        misaligned_s;
    logic [1:0]  fault_s;

    assign ea_s   = lsu.BASE + lsu.OFFSET;
    // 33-bit end address so a request straddling 2^32 still reads as out of range
    assign last_s = {1'b0, ea_s} + size_s - 33'd1;

    // Decode the request into access size, memory command and legality
    always_comb begin
        illegal_s = 1'b0;
        size_s    = 33'd1;
        cmd_s     = 4'b0000;
        if (lsu.REQ_LOAD == lsu.REQ_STORE) begin
            illegal_s = 1'b1;
        end else if (lsu.REQ_LOAD) begin
            cmd_s = {1'b1, lsu.FUNCT3};
            case (lsu.FUNCT3)
                3'b000, 3'b100: size_s = 33'd1;
                3'b001, 3'b101: size_s = 33'd2;
                3'b010:         size_s = 33'd4;
                default:        illegal_s = 1'b1;
            endcase
        end else begin
            case (lsu.FUNCT3)
                3'b000: begin size_s = 33'd1; cmd_s = 4'b1011; end
                3'b001: begin size_s = 33'd2; cmd_s = 4'b1110; end
                3'b010: begin size_s = 33'd4; cmd_s = 4'b1111; end
                default: illegal_s = 1'b1;
            endcase
        end
    end

    // Prioritised fault code: illegal, then misaligned, then out of range
    always_comb begin
        misaligned_s = ALIGN_CHECK &&
                       (((size_s == 33'd2) && ea_s[0]) ||
                        ((size_s == 33'd4) && (ea_s[1:0] != 2'b00)));
        if (illegal_s) begin
            fault_s = 2'b11;
        end else if (misaligned_s) begin
            fault_s = 2'b01;
        end else if (last_s > LAST_BYTE_C) begin
            fault_s = 2'b10;
        end else begin
            fault_s = 2'b00;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (lsu.REQ_VALID) begin
                    state_next_s = (fault_s != 2'b00) ? RESP : ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE:   state_next_s = is_load_r ? WAIT : RESP;
            WAIT:    state_next_s = RESP;
            RESP:    state_next_s = lsu.RESP_READY ? IDLE : RESP;
            default: state_next_s = IDLE;
        endcase
    end

    // State register, handshake flags and the memory command registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r         <= IDLE;
            ready_r         <= 1'b1;
            resp_valid_r    <= 1'b0;
            mem_rw_en_r     <= 4'b0000;
            mem_address_r   <= 32'd0;
            mem_writedata_r <= 32'd0;
        end else begin
            state_r      <= state_next_s;
            ready_r      <= (state_next_s == IDLE);
            resp_valid_r <= (state_next_s == RESP);
            // The command is loaded on the accept edge so it is live for exactly the ISSUE cycle
            if (state_next_s == ISSUE) begin
                mem_rw_en_r     <= cmd_s;
                mem_address_r   <= ea_s;
                mem_writedata_r <= lsu.REQ_STORE ? lsu.STORE_DATA : 32'd0;
            end else begin
                mem_rw_en_r     <= 4'b0000;
                mem_address_r   <= 32'd0;
                mem_writedata_r <= 32'd0;
            end
        end
    end

    // Response payload and completion counters
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            is_load_r    <= 1'b0;
            resp_data_r  <= 32'd0;
            resp_fault_r <= 2'b00;
            load_cnt_r   <= 32'd0;
            store_cnt_r  <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (lsu.REQ_VALID) begin
                        is_load_r    <= lsu.REQ_LOAD;
                        resp_fault_r <= fault_s;
                        resp_data_r  <= 32'd0;
                    end
                end
                ISSUE: begin
                    if (!is_load_r) begin
                        store_cnt_r <= store_cnt_r + 32'd1;
                    end
                end
                WAIT: begin
                    resp_data_r <= lsu.MEM_READDATA;
                    load_cnt_r  <= load_cnt_r + 32'd1;
                end
                RESP: begin
                    if (lsu.RESP_READY) begin
                        resp_data_r  <= 32'd0;
                        resp_fault_r <= 2'b00;
                    end
                end
                default: begin
                    resp_data_r  <= 32'd0;
                    resp_fault_r <= 2'b00;
                end
            endcase
        end
    end

    assign lsu.REQ_READY     = ready_r;
    assign lsu.RESP_VALID    = resp_valid_r;
    assign lsu.RESP_DATA     = resp_data_r;
    assign lsu.RESP_FAULT    = resp_fault_r;
    assign lsu.MEM_RW_EN     = mem_rw_en_r;
    assign lsu.MEM_ADDRESS   = mem_address_r;
    assign lsu.MEM_WRITEDATA = mem_writedata_r;
    assign lsu.LOAD_CNT      = load_cnt_r;
    assign lsu.STORE_CNT     = store_cnt_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// responses and memory commands; independent monitors compare what the DUT presents.
module tb_load_store_unit;
    localparam longint MEMB = 524288;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        logic [31:0] lcnt;
        logic [31:0] scnt;
    } resp_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          is_store;
    } cmd_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    resp_t exp_q[$];
    cmd_t  cmd_q[$];
    logic [31:0] exp_lcnt = 32'd0;
    logic [31:0] exp_scnt = 32'd0;

    bit [7:0] phys_mem [0:524287];
    bit [7:0] ref_mem  [0:524287];
    logic        pre_en;
    logic [18:0] pre_addr;
    logic [7:0]  pre_data;
    logic [18:0] ma;

    load_store_unit_if bus ();
    load_store_unit_if bus_na ();

    load_store_unit #(.MEM_BYTES(524288), .ALIGN_CHECK(1'b1)) u_dut (
        .CLK(clk), .RESET_N(rst_n), .lsu(bus)
    );
    load_store_unit #(.MEM_BYTES(524288), .ALIGN_CHECK(1'b0)) u_dut_na (
        .CLK(clk), .RESET_N(rst_n), .lsu(bus_na)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Data memory: registered read data, writes at the end of the command cycle
    assign ma = bus.MEM_ADDRESS[18:0];
    always @(posedge clk) begin
        if (pre_en) phys_mem[pre_addr] <= pre_data;
        case (bus.MEM_RW_EN)
            4'b1000: bus.MEM_READDATA <= {{24{phys_mem[ma][7]}}, phys_mem[ma]};
            4'b1001: bus.MEM_READDATA <= {{16{phys_mem[ma+19'd1][7]}}, phys_mem[ma+19'd1], phys_mem[ma]};
            4'b1010: bus.MEM_READDATA <= {phys_mem[ma+19'd3], phys_mem[ma+19'd2], phys_mem[ma+19'd1], phys_mem[ma]};
            4'b1100: bus.MEM_READDATA <= {24'd0, phys_mem[ma]};
            4'b1101: bus.MEM_READDATA <= {16'd0, phys_mem[ma+19'd1], phys_mem[ma]};
            4'b1011: phys_mem[ma] <= bus.MEM_WRITEDATA[7:0];
            4'b1110: begin
                phys_mem[ma]        <= bus.MEM_WRITEDATA[7:0];
                phys_mem[ma+19'd1]  <= bus.MEM_WRITEDATA[15:8];
            end
            4'b1111: begin
                phys_mem[ma]        <= bus.MEM_WRITEDATA[7:0];
                phys_mem[ma+19'd1]  <= bus.MEM_WRITEDATA[15:8];
                phys_mem[ma+19'd2]  <= bus.MEM_WRITEDATA[23:16];
                phys_mem[ma+19'd3]  <= bus.MEM_WRITEDATA[31:24];
            end
            default: ;
        endcase
    end

    // Reference model: returns expected accept-to-valid latency and queues expectations
    function automatic int model(bit ld, bit st, logic [2:0] f3, logic [31:0] base,
                                 logic [31:0] off, logic [31:0] sd);
        logic [31:0] ea;
        int          size;
        bit          sgn;
        bit          illegal;
        resp_t       r;
        cmd_t        c;
        logic [31:0] v;
        ea = base + off;
        size = 1; sgn = 1'b0; illegal = 1'b0;
        if (ld == st) illegal = 1'b1;
        else if (ld) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: illegal = 1'b1;
            endcase
        end
        r.data = 32'd0;
        r.fault = 2'b00;
        if (illegal) r.fault = 2'b11;
        else if ((ea % size) != 0) r.fault = 2'b01;
        else if (longint'({32'd0, ea}) + longint'(size) - 64'sd1 > MEMB - 64'sd1) r.fault = 2'b10;
        if (r.fault != 2'b00) begin
            r.lcnt = exp_lcnt; r.scnt = exp_scnt;
            exp_q.push_back(r);
            return 1;
        end
        c.addr = ea; c.is_store = st; c.wdata = sd;
        if (st) begin
            c.cmd = (size == 1) ? 4'b1011 : (size == 2) ? 4'b1110 : 4'b1111;
            for (int i = 0; i < size; i++) ref_mem[int'(ea) + i] = 8'(sd >> (8 * i));
            exp_scnt = exp_scnt + 32'd1;
            r.lcnt = exp_lcnt; r.scnt = exp_scnt;
            cmd_q.push_back(c);
            exp_q.push_back(r);
            return 2;
        end
        c.cmd = {1'b1, f3};
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(ea) + i]) << (8 * i));
        if (sgn && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (sgn && size == 2) v = {{16{v[15]}}, v[15:0]};
        exp_lcnt = exp_lcnt + 32'd1;
        r.data = v; r.lcnt = exp_lcnt; r.scnt = exp_scnt;
        cmd_q.push_back(c);
        exp_q.push_back(r);
        return 3;
    endfunction

    // Response monitor: every cycle RESP_VALID is high it must match the head entry
    always @(negedge clk) begin
        if (rst_n && bus.RESP_VALID) begin
            if (exp_q.size() == 0) chk("resp_unexpected", {31'd0, bus.RESP_VALID}, 32'd0);
            else begin
                chk("resp_data",  bus.RESP_DATA, exp_q[0].data);
                chk("resp_fault", {30'd0, bus.RESP_FAULT}, {30'd0, exp_q[0].fault});
                chk("load_cnt",   bus.LOAD_CNT, exp_q[0].lcnt);
                chk("store_cnt",  bus.STORE_CNT, exp_q[0].scnt);
                if (bus.RESP_READY) void'(exp_q.pop_front());
            end
        end
    end

    // Command monitor: each non-zero memory command must match the next predicted one
    always @(negedge clk) begin
        if (rst_n && bus.MEM_RW_EN != 4'd0) begin
            if (cmd_q.size() == 0) chk("cmd_unexpected", {28'd0, bus.MEM_RW_EN}, 32'd0);
            else begin
                chk("mem_rw_en", {28'd0, bus.MEM_RW_EN}, {28'd0, cmd_q[0].cmd});
                chk("mem_address", bus.MEM_ADDRESS, cmd_q[0].addr);
                if (cmd_q[0].is_store) chk("mem_writedata", bus.MEM_WRITEDATA, cmd_q[0].wdata);
                void'(cmd_q.pop_front());
            end
        end
    end

    task automatic drive(bit ld, bit st, logic [2:0] f3, logic [31:0] base,
                         logic [31:0] off, logic [31:0] sd);
        bus.REQ_VALID = 1'b1; bus.REQ_LOAD = ld; bus.REQ_STORE = st;
        bus.FUNCT3 = f3; bus.BASE = base; bus.OFFSET = off; bus.STORE_DATA = sd;
    endtask

    task automatic run_req(bit ld, bit st, logic [2:0] f3, logic [31:0] base,
                           logic [31:0] off, logic [31:0] sd, int hold);
        int exp_lat;
        int lat;
        exp_lat = model(ld, st, f3, base, off, sd);
        @(posedge clk); #1;
        chk("ready_idle", {31'd0, bus.REQ_READY}, 32'd1);
        drive(ld, st, f3, base, off, sd);
        @(posedge clk); #1;
        bus.REQ_VALID = 1'b0;
        lat = 1;
        while (!bus.RESP_VALID && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        for (int h = 0; h < hold; h++) begin
            chk("busy_ready", {31'd0, bus.REQ_READY}, 32'd0);
            @(posedge clk); #1;
        end
        bus.RESP_READY = 1'b1;
        @(posedge clk); #1;
        bus.RESP_READY = 1'b0;
        chk("idle_after_ready", {30'd0, bus.REQ_READY, bus.RESP_VALID}, 32'd2);
    endtask

    task automatic na_req(bit st, logic [2:0] f3, logic [31:0] ea,
                          logic [3:0] exp_cmd, logic [1:0] exp_fault);
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus_na.REQ_VALID = 1'b1; bus_na.REQ_LOAD = !st; bus_na.REQ_STORE = st;
        bus_na.FUNCT3 = f3; bus_na.BASE = ea; bus_na.OFFSET = 32'd0;
        bus_na.STORE_DATA = 32'h1122_3344;
        @(posedge clk); #1;
        bus_na.REQ_VALID = 1'b0;
        lat = 0; seen = 1'b0;
        while (!bus_na.RESP_VALID && lat < 8) begin
            if (bus_na.MEM_RW_EN != 4'd0) begin
                chk("na_cmd", {28'd0, bus_na.MEM_RW_EN}, {28'd0, exp_cmd});
                chk("na_addr", bus_na.MEM_ADDRESS, ea);
                seen = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("na_issued", {31'd0, seen}, {31'd0, exp_fault == 2'b00});
        chk("na_valid", {31'd0, bus_na.RESP_VALID}, 32'd1);
        chk("na_fault", {30'd0, bus_na.RESP_FAULT}, {30'd0, exp_fault});
        chk("na_data", bus_na.RESP_DATA, (exp_fault == 2'b00 && !st) ? 32'hCAFE_F00D : 32'd0);
        bus_na.RESP_READY = 1'b1;
        @(posedge clk); #1;
        bus_na.RESP_READY = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] b;
        logic [31:0] o;
        int          sel;
        int          t;
        rst_n = 1'b0;
        pre_en = 1'b0; pre_addr = 19'd0; pre_data = 8'd0;
        bus.REQ_VALID = 1'b0; bus.REQ_LOAD = 1'b0; bus.REQ_STORE = 1'b0;
        bus.FUNCT3 = 3'd0; bus.BASE = 32'd0; bus.OFFSET = 32'd0; bus.STORE_DATA = 32'd0;
        bus.RESP_READY = 1'b0;
        bus_na.REQ_VALID = 1'b0; bus_na.REQ_LOAD = 1'b0; bus_na.REQ_STORE = 1'b0;
        bus_na.FUNCT3 = 3'd0; bus_na.BASE = 32'd0; bus_na.OFFSET = 32'd0;
        bus_na.STORE_DATA = 32'd0; bus_na.RESP_READY = 1'b0;
        bus_na.MEM_READDATA = 32'hCAFE_F00D;

        @(posedge clk); #1;
        pre_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            pre_addr = 19'h140 + 19'(k);
            pre_data = 8'($urandom);
            ref_mem[32'h140 + k] = pre_data;
            @(posedge clk); #1;
        end
        pre_addr = 19'h100; pre_data = 8'h80; ref_mem[32'h100] = 8'h80;
        @(posedge clk); #1;
        pre_en = 1'b0;

        chk("rst_req_ready", {31'd0, bus.REQ_READY}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.RESP_VALID}, 32'd0);
        chk("rst_resp_data", bus.RESP_DATA, 32'd0);
        chk("rst_resp_fault", {30'd0, bus.RESP_FAULT}, 32'd0);
        chk("rst_mem_rw_en", {28'd0, bus.MEM_RW_EN}, 32'd0);
        chk("rst_mem_address", bus.MEM_ADDRESS, 32'd0);
        chk("rst_mem_writedata", bus.MEM_WRITEDATA, 32'd0);
        chk("rst_load_cnt", bus.LOAD_CNT, 32'd0);
        chk("rst_store_cnt", bus.STORE_CNT, 32'd0);
        rst_n = 1'b1;

        run_req(1'b1, 1'b0, 3'b000, 32'h0F0, 32'h10, 32'd0, 0);
        run_req(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 0);
        run_req(1'b1, 1'b0, 3'b101, 32'h200, 32'h2, 32'd0, 0);
        run_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h3, 32'd0, 0);
        run_req(1'b0, 1'b1, 3'b001, 32'h7FFFF, 32'h0, 32'h0000_1234, 0);
        run_req(1'b0, 1'b1, 3'b001, 32'h7FFFE, 32'h0, 32'h0000_5678, 0);
        run_req(1'b1, 1'b0, 3'b010, 32'h7FFFC, 32'h0, 32'd0, 0);
        run_req(1'b1, 1'b0, 3'b010, 32'h7FFFC, 32'h4, 32'd0, 0);
        run_req(1'b1, 1'b1, 3'b000, 32'h100, 32'h0, 32'd0, 0);
        run_req(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'd0, 0);
        run_req(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'd0, 0);
        run_req(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'd0, 5);

        // Reset while the load sits in WAIT abandons it
        void'(model(1'b1, 1'b0, 3'b010, 32'h180, 32'h0, 32'd0));
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b010, 32'h180, 32'h0, 32'd0);
        @(posedge clk); #1;
        bus.REQ_VALID = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", {31'd0, bus.RESP_VALID}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, bus.REQ_READY}, 32'd1);
        chk("mid_rst_mem_rw_en", {28'd0, bus.MEM_RW_EN}, 32'd0);
        chk("mid_rst_load_cnt", bus.LOAD_CNT, 32'd0);
        chk("mid_rst_store_cnt", bus.STORE_CNT, 32'd0);
        exp_q.delete();
        cmd_q.delete();
        exp_lcnt = 32'd0;
        exp_scnt = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_req(1'b1, 1'b0, 3'b010, 32'h140, 32'h0, 32'd0, 0);

        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin ld = 1'b1; st = 1'b1; end
            else if (sel == 1) begin ld = 1'b0; st = 1'b0; end
            else if (sel < 11) begin ld = 1'b1; st = 1'b0; end
            else begin ld = 1'b0; st = 1'b1; end
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            sel = int'($urandom_range(0, 15));
            if (sel < 12) begin
                b = 32'($urandom_range(0, 1023));
                t = int'($urandom_range(0, 64)) - 32;
                o = t;
            end else if (sel < 15) begin
                b = 32'h0007_FFF0;
                o = 32'($urandom_range(0, 31));
            end else begin
                b = $urandom;
                o = $urandom;
            end
            if ($urandom_range(0, 1) == 1) begin b[1:0] = 2'b00; o[1:0] = 2'b00; end
            run_req(ld, st, f3, b, o, $urandom, int'($urandom_range(0, 3)));
        end

        na_req(1'b0, 3'b010, 32'h103, 4'b1010, 2'b00);
        na_req(1'b1, 3'b001, 32'h7FFFF, 4'b0000, 2'b10);
        na_req(1'b1, 3'b001, 32'h101, 4'b1110, 2'b00);

        chk("resp_queue_drained", exp_q.size(), 32'd0);
        chk("cmd_queue_drained", cmd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
